mtsp_trds_fetch_scheduler: RTL and testbench
============================================

// Module: mtsp_trds_fetch_scheduler
// PURPOSE
//  Drives the thread-primitive fetch interface: selects one thread per probe via active-low one-hot IF_nEN.
//  Samples IF_RUN/IF_PC and issues fetch requests to instruction memory with valid/ack.
//  Allows one outstanding fetch per thread; round-robin fairness across the 12 hardware threads.
//  Sits between the thread primitive and the instruction-cache/fetch unit.
// PARAMETERS
//  TRD_COUNT  12  number of hardware threads (matches RANGE_TRDs)
//  PC_W       16  program-counter width (matches RANGE_PC)
//  TID_W      4   thread-id width, >= clog2(TRD_COUNT)
// PORTS
//  CLK           in   1          main clock
//  nRST          in   1          reset, synchronous, active-low
//  IF_nEN        out  TRD_COUNT  thread probe select, active-low one-hot; all-ones = no probe
//  IF_RUN        in   1          selected thread is runnable (combinational from the primitive)
//  IF_PC         in   PC_W       PC of the selected thread
//  FE_REQ        out  1          fetch request valid
//  FE_PC         out  PC_W       fetch address
//  FE_TID        out  TID_W      requesting thread id
//  FE_ACK        in   1          fetch unit accepts request this cycle
//  FE_RSP_VALID  in   1          fetch response returned
//  FE_RSP_TID    in   TID_W      thread id of the response
//  FE_HOLD       in   1          downstream stall; no new probe starts while high
//  SCH_IDLE      out  1          no fetch in flight and FSM in PROBE with nothing runnable
// BEHAVIOUR
//  Reset (nRST=0 at posedge): state=PROBE, ptr=0, inflight=0, IF_nEN=all-ones, FE_REQ=0, FE_PC=0,
//   FE_TID=0, SCH_IDLE=1. Reset mid-request drops the request; no ACK is awaited.
//  States: PROBE, ISSUE.
//  PROBE: cand = first thread at or after ptr (wrapping at TRD_COUNT-1 -> 0) with inflight[cand]=0.
//   If none exist or FE_HOLD=1: IF_nEN=all-ones and stay in PROBE.
//   Otherwise IF_nEN[cand]=0 (combinational from cand/state) and IF_RUN is sampled this cycle:
//   - IF_RUN=1: latch FE_PC<=IF_PC, FE_TID<=cand, inflight[cand]<=1, go to ISSUE.
//   - IF_RUN=0: ptr<=cand+1 (wrapping), stay in PROBE. Exactly one thread is probed per cycle.
//  ISSUE: FE_REQ=1, IF_nEN=all-ones; FE_PC/FE_TID held stable until FE_ACK.
//   On FE_ACK: FE_REQ<=0, ptr<=FE_TID+1 (wrapping), go to PROBE.
//   Issue latency: probe cycle to FE_REQ is 1 cycle; minimum 2 cycles per issued fetch.
//  FE_RSP_VALID: inflight[FE_RSP_TID]<=0 next cycle.
//   - Response in the same cycle as a PROBE of another thread: both take effect.
//   - Response for the thread being latched in the same cycle: the set wins (new fetch in flight).
//   - FE_RSP_TID >= TRD_COUNT, or a response for a thread with inflight=0: ignored, no state change.
//  ptr arithmetic is modulo TRD_COUNT and never holds a value >= TRD_COUNT.
//  SCH_IDLE registered: 1 when inflight==0 and next state is PROBE with no runnable thread found.
//  IF_nEN is never multi-hot; the primitive's lowest-index priority mux is therefore never exercised.
// STRUCTURE
//  Shared package mtsp_sched_pkg: TRD_COUNT, TID_W, sched_state_e {PROBE, ISSUE}, tid_t typedef.
//  Sub-module mtsp_rr_pick: combinational round-robin finder (mask, ptr -> cand, found).
//   Implemented as a double-width priority search; reused by other MTSP arbiters.
//  Top: FSM, ptr register, inflight vector, request register.
// TESTING
//  1. Reset, thread 5 only runnable, IF_PC=0x0120, FE_ACK tied 1
//     -> IF_nEN probes 0..5; FE_REQ with FE_PC=0x0120, FE_TID=5; inflight[5]=1.
//  2. All 12 runnable, FE_ACK=1, immediate responses
//     -> FE_TID sequence 0,1,...,11,0 with no thread granted twice within 12 grants.
//  3. Thread 3 issued, FE_ACK low for 4 cycles
//     -> FE_REQ, FE_PC and FE_TID stable for 4 cycles; IF_nEN=all-ones; deassert the cycle after ACK.
//  4. All threads in flight -> IF_nEN=0xFFF, no FE_REQ;
//     FE_RSP_VALID with TID=7 -> thread 7 probed the next cycle.
//  5. FE_HOLD=1 for 3 cycles while threads are runnable -> no probe, no request; resumes at ptr afterwards.
//  6. nRST low during ISSUE (FE_TID=9) -> FE_REQ=0 and inflight=0 after the reset edge; the first probe targets thread 0.

Source files
------------

// File: rtl/mtsp_sched_pkg.sv
// Shared constants and types for the MTSP thread schedulers.
package mtsp_sched_pkg;

  localparam int TRD_COUNT = 12;
  localparam int PC_W      = 16;
  localparam int TID_W     = 4;

  typedef logic [TID_W-1:0] tid_t;

  typedef enum logic {PROBE, ISSUE} sched_state_e;

  // Thread-id increment that wraps at the last hardware thread.
  function automatic tid_t tid_inc(input tid_t t);
    return (t == tid_t'(TRD_COUNT - 1)) ? '0 : t + tid_t'(1);
  endfunction

endpackage

// File: rtl/mtsp_rr_pick.sv
// Round-robin finder: first set bit of mask at or after ptr, wrapping around.
module mtsp_rr_pick
  import mtsp_sched_pkg::*;
(
  input  logic [TRD_COUNT-1:0] mask,
  input  tid_t                 ptr,
  output tid_t                 cand,
  output logic                 found
);

  logic [2*TRD_COUNT-1:0] dbl;

  assign dbl = {mask, mask};

  // Scanning downward leaves the lowest qualifying position of the doubled vector.
  always_comb begin
    cand  = '0;
    found = 1'b0;
    for (int i = 2*TRD_COUNT-1; i >= 0; i--) begin
      if (dbl[i] && (i >= int'(ptr))) begin
        cand  = tid_t'(i % TRD_COUNT);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mtsp_trds_fetch_scheduler.sv
// Probes hardware threads round-robin and issues one fetch per thread to the fetch unit.
module mtsp_trds_fetch_scheduler
  import mtsp_sched_pkg::*;
(
  input  logic                 CLK,
  input  logic                 nRST,
  output logic [TRD_COUNT-1:0] IF_nEN,
  input  logic                 IF_RUN,
  input  logic [PC_W-1:0]      IF_PC,
  output logic                 FE_REQ,
  output logic [PC_W-1:0]      FE_PC,
  output logic [TID_W-1:0]     FE_TID,
  input  logic                 FE_ACK,
  input  logic                 FE_RSP_VALID,
  input  logic [TID_W-1:0]     FE_RSP_TID,
  input  logic                 FE_HOLD,
  output logic                 SCH_IDLE
);

  sched_state_e         state;
  tid_t                 ptr;
  logic [TRD_COUNT-1:0] inflight;
  logic [TRD_COUNT-1:0] inflight_nxt;
  tid_t                 cand;
  logic                 found;
  logic                 probe;
  logic                 grant;

  mtsp_rr_pick u_pick (
    .mask  (~inflight),
    .ptr   (ptr),
    .cand  (cand),
    .found (found)
  );

  assign probe = (state == PROBE) && found && !FE_HOLD;
  assign grant = probe && IF_RUN;

  always_comb begin
    IF_NEN_DEFAULT: begin
      IF_nEN = '1;
    end
    if (probe) IF_nEN[cand] = 1'b0;
  end

  // A grant in the same cycle as a response for that thread keeps it in flight.
  always_comb begin
    inflight_nxt = inflight;
    if (FE_RSP_VALID && (FE_RSP_TID < tid_t'(TRD_COUNT))) inflight_nxt[FE_RSP_TID] = 1'b0;
    if (grant) inflight_nxt[cand] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state    <= PROBE;
      ptr      <= '0;
      inflight <= '0;
      FE_REQ   <= 1'b0;
      FE_PC    <= '0;
      FE_TID   <= '0;
      SCH_IDLE <= 1'b1;
    end else begin
      inflight <= inflight_nxt;
      SCH_IDLE <= (state == PROBE) && !grant && (inflight_nxt == '0);
      case (state)
        PROBE: begin
          if (grant) begin
            FE_PC  <= IF_PC;
            FE_TID <= cand;
            FE_REQ <= 1'b1;
            state  <= ISSUE;
          end else if (probe) begin
            ptr <= tid_inc(cand);
          end
        end
        ISSUE: begin
          if (FE_ACK) begin
            FE_REQ <= 1'b0;
            ptr    <= tid_inc(FE_TID);
            state  <= PROBE;
          end
        end
        default: state <= PROBE;
      endcase
    end
  end

endmodule

// File: tb/tb_mtsp_trds_fetch_scheduler.sv
// Self-checking bench: thread-primitive model plus a cycle-level reference of the scheduling rules.
module tb_mtsp_trds_fetch_scheduler;
  import mtsp_sched_pkg::*;

  localparam int N = 12;

  logic          CLK = 1'b0;
  logic          nRST;
  logic [N-1:0]  IF_nEN;
  logic          IF_RUN;
  logic [15:0]   IF_PC;
  logic          FE_REQ;
  logic [15:0]   FE_PC;
  logic [3:0]    FE_TID;
  logic          FE_ACK;
  logic          FE_RSP_VALID;
  logic [3:0]    FE_RSP_TID;
  logic          FE_HOLD;
  logic          SCH_IDLE;

  mtsp_trds_fetch_scheduler dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .IF_nEN       (IF_nEN),
    .IF_RUN       (IF_RUN),
    .IF_PC        (IF_PC),
    .FE_REQ       (FE_REQ),
    .FE_PC        (FE_PC),
    .FE_TID       (FE_TID),
    .FE_ACK       (FE_ACK),
    .FE_RSP_VALID (FE_RSP_VALID),
    .FE_RSP_TID   (FE_RSP_TID),
    .FE_HOLD      (FE_HOLD),
    .SCH_IDLE     (SCH_IDLE)
  );

  always #5 CLK = ~CLK;

  bit   [N-1:0] run_mask;
  logic [15:0]  pc_arr [N];
  bit           rand_pc;

  // Thread primitive: lowest-index selected thread drives RUN/PC.
  always_comb begin
    IF_RUN = 1'b0;
    IF_PC  = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (IF_nEN[i] === 1'b0) begin
        IF_RUN = run_mask[i];
        IF_PC  = pc_arr[i];
      end
    end
  end

  // Reference state
  bit          m_valid;
  bit          m_issue;
  int          m_ptr;
  bit          m_inf [N];
  logic [15:0] m_pc;
  int          m_tid;
  bit          m_idle;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int modelCand();
    for (int k = 0; k < N; k++) begin
      int t;
      t = (m_ptr + k) % N;
      if (!m_inf[t]) return t;
    end
    return -1;
  endfunction

  task automatic modelReset();
    m_valid = 1'b1;
    m_issue = 1'b0;
    m_ptr   = 0;
    foreach (m_inf[i]) m_inf[i] = 1'b0;
    m_pc    = '0;
    m_tid   = 0;
    m_idle  = 1'b1;
  endtask

  // One clock cycle: drive inputs, check outputs against the reference, advance the reference.
  task automatic applyStimulus(input bit rst_n, input bit hold, input bit ack,
                               input bit rsp_v, input int rsp_tid, input bit [N-1:0] mask);
    int          cand;
    bit          probe;
    bit          grant;
    bit          old_issue;
    bit          any;
    logic [N-1:0] exp_nen;
    @(posedge CLK);
    #1;
    nRST         = rst_n;
    FE_HOLD      = hold;
    FE_ACK       = ack;
    FE_RSP_VALID = rsp_v;
    FE_RSP_TID   = 4'(rsp_tid);
    run_mask     = mask;
    if (rand_pc) foreach (pc_arr[i]) pc_arr[i] = 16'($urandom);
    #3;
    cand    = modelCand();
    probe   = m_valid && !m_issue && (cand >= 0) && !hold;
    exp_nen = '1;
    if (probe) exp_nen[cand] = 1'b0;
    if (m_valid) begin
      checkOutput("if_nen",   32'(IF_nEN),   32'(exp_nen));
      checkOutput("fe_req",   32'(FE_REQ),   32'(m_issue));
      checkOutput("fe_pc",    32'(FE_PC),    32'(m_pc));
      checkOutput("fe_tid",   32'(FE_TID),   32'(m_tid));
      checkOutput("sch_idle", 32'(SCH_IDLE), 32'(m_idle));
    end
    if (!rst_n) begin
      modelReset();
    end else if (m_valid) begin
      grant     = probe && mask[cand];
      old_issue = m_issue;
      if (!m_issue) begin
        if (grant) begin
          m_pc    = pc_arr[cand];
          m_tid   = cand;
          m_issue = 1'b1;
        end else if (probe) begin
          m_ptr = (cand + 1) % N;
        end
      end else if (ack) begin
        m_issue = 1'b0;
        m_ptr   = (m_tid + 1) % N;
      end
      if (rsp_v && rsp_tid < N) m_inf[rsp_tid] = 1'b0;
      if (grant) m_inf[cand] = 1'b1;
      any = 1'b0;
      foreach (m_inf[i]) any |= m_inf[i];
      m_idle = !old_issue && !grant && !any;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int     grants [$];
    bit     rv;
    bit     seen;
    m_valid      = 1'b0;
    rand_pc      = 1'b0;
    nRST         = 1'b0;
    FE_HOLD      = 1'b0;
    FE_ACK       = 1'b0;
    FE_RSP_VALID = 1'b0;
    FE_RSP_TID   = '0;
    run_mask     = '0;
    foreach (pc_arr[i]) pc_arr[i] = 16'h1000 + 16'(i * 16);

    // Reset state
    applyStimulus(0, 0, 0, 0, 0, '0);
    applyStimulus(0, 0, 0, 0, 0, '0);
    applyStimulus(1, 0, 0, 0, 0, '0);
    checkOutput("rst_req",  32'(FE_REQ),   32'd0);
    checkOutput("rst_idle", 32'(SCH_IDLE), 32'd1);
    checkOutput("rst_nen",  32'(IF_nEN),   32'h0FFE);

    // Only thread 5 runnable
    applyStimulus(0, 0, 1, 0, 0, '0);
    pc_arr[5] = 16'h0120;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      applyStimulus(1, 0, 1, 0, 0, 12'(1 << 5));
      seen = (FE_REQ === 1'b1);
    end
    checkOutput("s1_req", 32'(FE_REQ), 32'd1);
    checkOutput("s1_tid", 32'(FE_TID), 32'd5);
    checkOutput("s1_pc",  32'(FE_PC),  32'h0120);
    applyStimulus(1, 0, 1, 1, 5, 12'(1 << 5));

    // All runnable, immediate responses: strict rotation
    applyStimulus(0, 0, 1, 0, 0, '1);
    for (int c = 0; c < 30; c++) begin
      rv = m_issue;
      applyStimulus(1, 0, 1, rv, m_tid, '1);
      if (FE_REQ === 1'b1) grants.push_back(int'(FE_TID));
    end
    checkOutput("s2_count", 32'(grants.size() >= 13), 32'd1);
    for (int i = 0; i < 13 && i < grants.size(); i++)
      checkOutput("s2_order", 32'(grants[i]), 32'(i % N));

    // Back-pressure on thread 3
    applyStimulus(0, 0, 0, 0, 0, '0);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      applyStimulus(1, 0, 0, 0, 0, 12'(1 << 3));
      seen = (FE_REQ === 1'b1);
    end
    for (int c = 0; c < 4; c++) begin
      if (c > 0) applyStimulus(1, 0, 0, 0, 0, 12'(1 << 3));
      checkOutput("s3_req", 32'(FE_REQ), 32'd1);
      checkOutput("s3_tid", 32'(FE_TID), 32'd3);
      checkOutput("s3_pc",  32'(FE_PC),  32'(pc_arr[3]));
      checkOutput("s3_nen", 32'(IF_nEN), 32'h0FFF);
    end
    applyStimulus(1, 0, 1, 0, 0, 12'(1 << 3));
    applyStimulus(1, 0, 1, 0, 0, 12'(1 << 3));
    checkOutput("s3_drop", 32'(FE_REQ), 32'd0);

    // Every thread in flight, then a single response for thread 7
    applyStimulus(0, 0, 0, 0, 0, '0);
    for (int c = 0; c < 30; c++) applyStimulus(1, 0, 1, 0, 0, '1);
    checkOutput("s4_nen", 32'(IF_nEN), 32'h0FFF);
    checkOutput("s4_req", 32'(FE_REQ), 32'd0);
    applyStimulus(1, 0, 1, 1, 7, '1);
    applyStimulus(1, 0, 1, 0, 0, '1);
    checkOutput("s4_probe7", 32'(IF_nEN), 32'h0F7F);

    // Downstream hold
    applyStimulus(0, 0, 0, 0, 0, '0);
    for (int c = 0; c < 3; c++) applyStimulus(1, 0, 1, 0, 0, '1);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1, 1, 1, 0, 0, '1);
      checkOutput("s5_nen", 32'(IF_nEN), 32'h0FFF);
    end
    for (int c = 0; c < 6; c++) applyStimulus(1, 0, 1, 0, 0, '1);

    // Reset while issuing thread 9
    applyStimulus(0, 0, 0, 0, 0, '0);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      applyStimulus(1, 0, 0, 0, 0, 12'(1 << 9));
      seen = (FE_REQ === 1'b1);
    end
    checkOutput("s6_tid", 32'(FE_TID), 32'd9);
    applyStimulus(0, 0, 0, 0, 0, '1);
    applyStimulus(1, 0, 0, 0, 0, '1);
    checkOutput("s6_req",  32'(FE_REQ),   32'd0);
    checkOutput("s6_nen",  32'(IF_nEN),   32'h0FFE);
    checkOutput("s6_idle", 32'(SCH_IDLE), 32'd1);

    // Randomized traffic
    rand_pc = 1'b1;
    for (int c = 0; c < 400; c++) begin
      applyStimulus(($urandom_range(0, 99) != 0),
                    ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 1) == 1),
                    ($urandom_range(0, 2) == 0),
                    int'($urandom_range(0, 15)),
                    12'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
